// File: rtl/ks_alu_pkg.sv
// Shared types and elaboration helpers for the sparse Kogge-Stone add/sub unit.
package ks_alu_pkg;

  typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} op_e;

  localparam int KS_MIN_WIDTH = 8;
  localparam int KS_MAX_WIDTH = 64;

  // Number of prefix levels needed to cover width/sparsity groups.
  function automatic int ks_levels(input int width, input int sparsity);
    int groups;
    int lv;
    groups = width / sparsity;
    lv = 0;
    while ((1 << lv) < groups) lv++;
    return lv;
  endfunction

endpackage

// File: rtl/ks_prefix_tree.sv
// Combinational Kogge-Stone prefix over group generate/propagate; grp_c[k] is the carry into group k.
module ks_prefix_tree
  import ks_alu_pkg::*;
#(
  parameter int N_GROUPS = 8
) (
  input  logic [N_GROUPS-1:0] grp_g,
  input  logic [N_GROUPS-1:0] grp_p,
  input  logic                cin,
  output logic [N_GROUPS:0]   grp_c
);

  localparam int LEVELS = ks_levels(N_GROUPS, 1);

  genvar l, i;
  generate
    for (l = 0; l <= LEVELS; l++) begin : lvl
      logic [N_GROUPS-1:0] g;
      logic [N_GROUPS-1:0] p;
      if (l == 0) begin : base
        assign g = grp_g;
        assign p = grp_p;
      end else begin : comb
        localparam int D = 1 << (l - 1);
        for (i = 0; i < N_GROUPS; i++) begin : node
          if (i >= D) begin : op
            assign g[i] = lvl[l-1].g[i] | (lvl[l-1].p[i] & lvl[l-1].g[i-D]);
            assign p[i] = lvl[l-1].p[i] & lvl[l-1].p[i-D];
          end else begin : pass
            assign g[i] = lvl[l-1].g[i];
            assign p[i] = lvl[l-1].p[i];
          end
        end
      end
    end
  endgenerate

  // Fold the external carry-in into every prefix span [k:0].
  assign grp_c[0] = cin;
  for (i = 0; i < N_GROUPS; i++) begin : g_cout
    assign grp_c[i+1] = lvl[LEVELS].g[i] | (lvl[LEVELS].p[i] & cin);
  end

endmodule

// File: rtl/sparse_ks_addsub_pipe.sv
// 3-stage add/subtract on a sparse Kogge-Stone tree; one global stall, in_ready = !out_valid || out_ready.
// Optional KS_ADDSUB_SAT_EN adds in_sat for signed saturation on overflow.
module sparse_ks_addsub_pipe
  import ks_alu_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int SPARSITY = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_ci,
`ifdef KS_ADDSUB_SAT_EN
  input  logic             in_sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_co,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_ovf
);

  localparam int N_GROUPS = WIDTH / SPARSITY;

  if ((WIDTH % SPARSITY) != 0 || WIDTH < KS_MIN_WIDTH || WIDTH > KS_MAX_WIDTH) begin : g_bad_width
    $error("sparse_ks_addsub_pipe: illegal WIDTH %0d for SPARSITY %0d", WIDTH, SPARSITY);
  end
  if (SPARSITY != 2 && SPARSITY != 4) begin : g_bad_sparsity
    $error("sparse_ks_addsub_pipe: illegal SPARSITY %0d", SPARSITY);
  end

  logic advance;
  logic accept;
  logic sat_req;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign accept   = in_valid && advance;

`ifdef KS_ADDSUB_SAT_EN
  assign sat_req = in_sat;
`else
  assign sat_req = 1'b0;
`endif

  // S1: subtraction becomes A + ~B + !borrow so the tree only ever adds.
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s1_ci;
  logic             s1_sat;
  op_e              s1_op;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_ci    <= 1'b0;
      s1_sat   <= 1'b0;
      s1_op    <= OP_ADD;
    end else if (advance) begin
      s1_valid <= accept;
      if (accept) begin
        s1_a   <= in_a;
        s1_b   <= in_sub ? ~in_b : in_b;
        s1_ci  <= in_sub ? !in_ci : in_ci;
        s1_sat <= sat_req;
        s1_op  <= in_sub ? OP_SUB : OP_ADD;
      end
    end
  end

  logic [WIDTH-1:0]    s1_g;
  logic [WIDTH-1:0]    s1_p;
  logic [N_GROUPS-1:0] grp_g;
  logic [N_GROUPS-1:0] grp_p;
  logic [N_GROUPS:0]   tree_c;

  assign s1_g = s1_a & s1_b;
  assign s1_p = s1_a ^ s1_b;

  always_comb begin
    grp_g = '0;
    grp_p = '0;
    for (int k = 0; k < N_GROUPS; k++) begin
      grp_p[k] = 1'b1;
      for (int j = 0; j < SPARSITY; j++) begin
        grp_g[k] = s1_g[k*SPARSITY+j] | (s1_p[k*SPARSITY+j] & grp_g[k]);
        grp_p[k] = grp_p[k] & s1_p[k*SPARSITY+j];
      end
    end
  end

  ks_prefix_tree #(.N_GROUPS(N_GROUPS)) u_tree (
    .grp_g (grp_g),
    .grp_p (grp_p),
    .cin   (s1_ci),
    .grp_c (tree_c)
  );

  // S2: bitwise G/P travel alongside the group carries for the S3 ripple.
  logic              s2_valid;
  logic [WIDTH-1:0]  s2_g;
  logic [WIDTH-1:0]  s2_p;
  logic [N_GROUPS:0] s2_c;
  logic              s2_sat;
  op_e               s2_op;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_g     <= '0;
      s2_p     <= '0;
      s2_c     <= '0;
      s2_sat   <= 1'b0;
      s2_op    <= OP_ADD;
    end else if (advance) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_g   <= s1_g;
        s2_p   <= s1_p;
        s2_c   <= tree_c;
        s2_sat <= s1_sat;
        s2_op  <= s1_op;
      end
    end
  end

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] res;
  logic             ovf;
  logic             ripple_c;

  always_comb begin
    sum      = '0;
    ripple_c = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if ((i % SPARSITY) == 0) ripple_c = s2_c[i/SPARSITY];
      sum[i]   = s2_p[i] ^ ripple_c;
      ripple_c = s2_g[i] | (s2_p[i] & ripple_c);
    end
  end

  // Operand MSBs agree iff p is 0 there, and then g holds the shared sign.
  assign ovf = !s2_p[WIDTH-1] && (sum[WIDTH-1] != s2_g[WIDTH-1]);

  always_comb begin
    res = sum;
    if (s2_sat && ovf) res = s2_g[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_res   <= '0;
      out_co    <= 1'b0;
      out_zero  <= 1'b0;
      out_neg   <= 1'b0;
      out_ovf   <= 1'b0;
    end else if (advance) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_res  <= res;
        out_co   <= (s2_op == OP_SUB) ? !s2_c[N_GROUPS] : s2_c[N_GROUPS];
        out_zero <= (res == '0);
        out_neg  <= res[WIDTH-1];
        out_ovf  <= ovf;
      end
    end
  end

endmodule

// File: tb/tb_sparse_ks_addsub_pipe.sv
// Scoreboard bench: an 8-bit instance for hand-computed vectors and reset, a 32-bit one for a stalled random stream.
`timescale 1ns/1ps
module tb_sparse_ks_addsub_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst8_n, iv8, ir8, sub8, ci8, sat8, ov8, ordy8, co8, z8, n8, f8;
  logic [7:0]  a8, b8, res8;
  logic        rst32_n, iv32, ir32, sub32, ci32, sat32, ov32, ordy32, co32, z32, n32, f32;
  logic [31:0] a32, b32, res32;

  sparse_ks_addsub_pipe #(.WIDTH(8), .SPARSITY(4)) u8 (
    .clk(clk), .rst_n(rst8_n), .in_valid(iv8), .in_ready(ir8),
    .in_a(a8), .in_b(b8), .in_sub(sub8), .in_ci(ci8),
`ifdef KS_ADDSUB_SAT_EN
    .in_sat(sat8),
`endif
    .out_valid(ov8), .out_ready(ordy8), .out_res(res8),
    .out_co(co8), .out_zero(z8), .out_neg(n8), .out_ovf(f8)
  );

  sparse_ks_addsub_pipe #(.WIDTH(32), .SPARSITY(4)) u32 (
    .clk(clk), .rst_n(rst32_n), .in_valid(iv32), .in_ready(ir32),
    .in_a(a32), .in_b(b32), .in_sub(sub32), .in_ci(ci32),
`ifdef KS_ADDSUB_SAT_EN
    .in_sat(sat32),
`endif
    .out_valid(ov32), .out_ready(ordy32), .out_res(res32),
    .out_co(co32), .out_zero(z32), .out_neg(n32), .out_ovf(f32)
  );

  typedef struct {
    logic [63:0] res;
    logic        co, zero, neg, ovf;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t q8[$];
  exp_t q32[$];
  exp_t e8, e32;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_on = 1'b0;
  bit   stim_done = 1'b0;
  logic        prev_stall = 1'b0;
  logic [67:0] prev_snap = '0;

  task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic straight from the operand definition.
  function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                 input logic sub, input logic ci, input logic sat);
    exp_t m;
    logic [64:0] full;
    logic [63:0] mask, be, res;
    logic        cout, sa, ovf;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    be   = sub ? (~b & mask) : b;
    full = {1'b0, a} + {1'b0, be} + 65'(sub ? !ci : ci);
    res  = full[63:0] & mask;
    cout = full[w];
    sa   = a[w-1];
    ovf  = (sa == be[w-1]) && (res[w-1] != sa);
    if (sat && ovf) res = sa ? (64'd1 << (w - 1)) : (mask >> 1);
    m.res  = res;
    m.co   = sub ? !cout : cout;
    m.zero = (res == 64'd0);
    m.neg  = res[w-1];
    m.ovf  = ovf;
    m.acc  = 0;
    m.lat  = 1'b0;
    return m;
  endfunction

  always @(negedge clk) begin
    if (mon_on && ov8 === 1'b1 && ordy8 === 1'b1) begin
      if (q8.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL u8 unexpected beat: got res %h with empty scoreboard", res8);
      end else begin
        e8 = q8.pop_front();
        chk("u8 result", {56'h0, res8, co8, z8, n8, f8}, {e8.res, e8.co, e8.zero, e8.neg, e8.ovf});
        if (e8.lat) chk("u8 latency", 68'(cyc - e8.acc), 68'd3);
      end
    end
  end

  always @(negedge clk) begin
    if (mon_on) begin
      chk("u32 in_ready", 68'(ir32), 68'(!(ov32 && !ordy32)));
      if (prev_stall) chk("u32 hold during stall", {31'h0, ov32, res32, co32, z32, n32, f32}, prev_snap);
      prev_stall <= ov32 && !ordy32;
      prev_snap  <= {31'h0, ov32, res32, co32, z32, n32, f32};
      if (ov32 === 1'b1 && ordy32 === 1'b1) begin
        if (q32.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL u32 unexpected beat: got res %h with empty scoreboard", res32);
        end else begin
          e32 = q32.pop_front();
          chk("u32 result", {32'h0, res32, co32, z32, n32, f32}, {e32.res, e32.co, e32.zero, e32.neg, e32.ovf});
        end
      end
    end
  end

  // Caller is just after a rising edge; returns just after the accepting edge.
  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic sub, input logic ci,
                       input logic sat, input logic [7:0] r, input logic co, input logic z,
                       input logic n, input logic v);
    exp_t e;
    int   w;
    iv8 = 1'b1; a8 = a; b8 = b; sub8 = sub; ci8 = ci; sat8 = sat;
    w = 0;
    @(negedge clk);
    while (!ir8 && w < 200) begin @(negedge clk); w++; end
    if (!ir8) begin
      n_cmp++; n_bad++;
      $display("FAIL u8 accept timeout: in_ready %b expected 1", ir8);
    end else begin
      e.res = 64'(r); e.co = co; e.zero = z; e.neg = n; e.ovf = v; e.acc = cyc; e.lat = 1'b1;
      q8.push_back(e);
    end
    @(posedge clk); #1;
    iv8 = 1'b0;
  endtask

  task automatic send32(input logic [31:0] a, input logic [31:0] b, input logic sub,
                        input logic ci, input logic sat);
    int w;
    iv32 = 1'b1; a32 = a; b32 = b; sub32 = sub; ci32 = ci; sat32 = sat;
    w = 0;
    @(negedge clk);
    while (!ir32 && w < 200) begin @(negedge clk); w++; end
    if (!ir32) begin
      n_cmp++; n_bad++;
      $display("FAIL u32 accept timeout: in_ready %b expected 1", ir32);
    end else begin
`ifdef KS_ADDSUB_SAT_EN
      q32.push_back(model(32, 64'(a), 64'(b), sub, ci, sat));
`else
      q32.push_back(model(32, 64'(a), 64'(b), sub, ci, 1'b0));
`endif
    end
    @(posedge clk); #1;
    iv32 = 1'b0;
  endtask

  initial begin
    rst8_n = 1'b0; rst32_n = 1'b0;
    iv8 = 0; a8 = 0; b8 = 0; sub8 = 0; ci8 = 0; sat8 = 0; ordy8 = 1'b1;
    iv32 = 0; a32 = 0; b32 = 0; sub32 = 0; ci32 = 0; sat32 = 0; ordy32 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst8_n = 1'b1; rst32_n = 1'b1;

    chk("u8 reset state", {55'h0, ov8, res8, co8, z8, n8, f8}, 68'h0);
    chk("u32 reset state", {31'h0, ov32, res32, co32, z32, n32, f32}, 68'h0);
    chk("u8 reset in_ready", 68'(ir8), 68'd1);
    chk("u32 reset in_ready", 68'(ir32), 68'd1);
    mon_on = 1'b1;

    //      A      B      sub   ci    sat   res    co    z     n     v
    send8(8'h05, 8'h03, 1'b1, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
    send8(8'h03, 8'h05, 1'b1, 1'b0, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b1, 1'b0);
    send8(8'h80, 8'h01, 1'b1, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1);
    send8(8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    send8(8'h10, 8'h10, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0);
    send8(8'h3C, 8'h45, 1'b0, 1'b1, 1'b0, 8'h82, 1'b0, 1'b0, 1'b1, 1'b1);
    send8(8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    send8(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1);
`ifdef KS_ADDSUB_SAT_EN
    send8(8'h7F, 8'h01, 1'b0, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1);
    send8(8'h80, 8'h01, 1'b1, 1'b0, 1'b1, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1);
`endif
    repeat (6) @(posedge clk);
    #1;

    // Two beats in flight, then a one-cycle reset must discard both.
    send8(8'h11, 8'h22, 1'b0, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0);
    send8(8'h44, 8'h11, 1'b1, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0);
    rst8_n = 1'b0;
    q8.delete();
    @(posedge clk); #1;
    rst8_n = 1'b1;
    chk("u8 after mid-flight reset", {55'h0, ov8, res8, co8, z8, n8, f8}, 68'h0);
    repeat (8) @(posedge clk);
    #1;
    send8(8'hA0, 8'h70, 1'b0, 1'b0, 1'b0, 8'h10, 1'b1, 1'b0, 1'b0, 1'b0);

    fork
      begin
        for (int i = 0; i < 100; i++) begin
          logic [31:0] ra, rb;
          ra = $urandom;
          rb = $urandom;
          case (i % 8)
            0: ra = 32'hFFFF_FFFF;
            1: rb = ra;
            2: begin ra = 32'h7FFF_FFFF; rb = 32'h0000_0001; end
            3: begin ra = 32'h8000_0000; rb = 32'h0000_0001; end
            default: ;
          endcase
          send32(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        stim_done = 1'b1;
      end
      begin
        while (!stim_done) begin
          @(posedge clk); #1;
          ordy32 = 1'($urandom_range(0, 1));
        end
        ordy32 = 1'b1;
      end
    join

    begin
      int w;
      w = 0;
      while ((q8.size() != 0 || q32.size() != 0) && w < 500) begin @(negedge clk); w++; end
      if (q8.size() != 0 || q32.size() != 0) begin
        n_cmp++; n_bad++;
        $display("FAIL drain timeout: %0d/%0d beats outstanding, expected 0", q8.size(), q32.size());
      end
    end
    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
